// File: rtl/pulse_count_ctrl.sv
// pulse_count_ctrl
//   Counts qualifying events on x after a start command and raises a
//   one-cycle g strobe when the programmable terminal count is reached.
//   Optional rising-edge event qualification: define PULSE_CNT_EDGE_EN.
//   Without it an event is simply x = 1 in a COUNT cycle (level mode).
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   start      in   begin / restart a count (q <- 0)
//   abort      in   cancel the current count, back to IDLE (highest priority)
//   x          in   event input
//   limit      in   terminal count, 0 means 2^WIDTH
//   auto_rearm in   restart automatically one cycle after terminal count
//   q          out  current count
//   g          out  terminal-count strobe, one cycle
//   busy       out  high while counting
//   done       out  high while holding the terminal value
module pulse_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             x,
  input  logic [WIDTH-1:0] limit,
  input  logic             auto_rearm,
  output logic [WIDTH-1:0] q,
  output logic             g,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic             event_s;
  logic [WIDTH-1:0] limit_m1_s;
  logic             terminal_s;

`ifdef PULSE_CNT_EDGE_EN
  logic x_prev_r;

  // Previous-cycle copy of x, sampled in every state so a level held
  // across a start still counts only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_prev_r <= 1'b0;
    end else begin
      x_prev_r <= x;
    end
  end

  assign event_s = x & ~x_prev_r;
`else
  assign event_s = x;
`endif

  // limit = 0 wraps to all-ones here, so the terminal event is the one
  // that takes q from all-ones back to 0 (2^WIDTH events).
  assign limit_m1_s = limit - ONE;
  assign terminal_s = (q == limit_m1_s);

  // Control FSM with registered counter and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      q       <= ZERO;
      g       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      g <= 1'b0;
      case (state_r)
        IDLE: begin
          if (abort) begin
            state_r <= IDLE;
          end else if (start) begin
            q       <= ZERO;
            state_r <= COUNT;
            busy    <= 1'b1;
            done    <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        COUNT: begin
          if (abort) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else if (start) begin
            q <= ZERO;
          end else if (event_s) begin
            q <= q + ONE;
            if (terminal_s) begin
              g       <= 1'b1;
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_r <= COUNT;
            end
          end else begin
            state_r <= COUNT;
          end
        end
        DONE: begin
          if (abort) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else if (start || auto_rearm) begin
            // Restart cycle: any event present now is deliberately dropped.
            q       <= ZERO;
            state_r <= COUNT;
            busy    <= 1'b1;
            done    <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          // Unreachable encoding 2'b11: fall back to a quiet IDLE.
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_count_ctrl.sv
module tb_pulse_count_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       x = 1'b0;
  logic       auto_rearm = 1'b0;
  logic [3:0] limit = 4'd0;
  logic [3:0] q;
  logic       g, busy, done;
  logic [7:0] limit8 = 8'd0;
  logic [7:0] q8;
  logic       g8, busy8, done8;

  int checks = 0;
  int errors = 0;

  pulse_count_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .x(x),
    .limit(limit), .auto_rearm(auto_rearm),
    .q(q), .g(g), .busy(busy), .done(done)
  );

  pulse_count_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .x(x),
    .limit(limit8), .auto_rearm(auto_rearm),
    .q(q8), .g(g8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s, a, xx, ar;
    logic [3:0] lim;
    logic [3:0] eq;
    logic       eg, eb, ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic a, logic xx, logic ar, logic [3:0] lim,
                              logic [3:0] eq, logic eg, logic eb, logic ed);
    vec_t v;
    v.s = s; v.a = a; v.xx = xx; v.ar = ar; v.lim = lim;
    v.eq = eq; v.eg = eg; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural reference: mode 0 idle, 1 counting, 2 holding terminal value.
  int m_mode, m_q;
  bit m_g, m_xprev;

  task automatic model_reset();
    m_mode = 0; m_q = 0; m_g = 0; m_xprev = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit xx, input bit ar, input int lim);
    bit ev;
`ifdef PULSE_CNT_EDGE_EN
    ev = xx && !m_xprev;
`else
    ev = xx;
`endif
    m_xprev = xx;
    m_g = 0;
    if (m_mode == 0) begin
      if (!a && s) begin m_q = 0; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (a) m_mode = 0;
      else if (s) m_q = 0;
      else if (ev) begin
        m_q = (m_q + 1) % 16;
        if (m_q == lim % 16) begin m_g = 1; m_mode = 2; end
      end
    end else begin
      if (a) m_mode = 0;
      else if (s || ar) begin m_q = 0; m_mode = 1; end
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic xx, input logic ar,
                       input logic [3:0] lim);
    @(negedge clk);
    start = s; abort = a; x = xx; auto_rearm = ar; limit = lim;
  endtask

  task automatic step(input logic s, input logic a, input logic xx, input logic ar,
                      input logic [3:0] lim);
    drive(s, a, xx, ar, lim);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; start = 1'b0; abort = 1'b0; x = 1'b0; auto_rearm = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  int first4, first8, q4_at, q8_at;

  initial begin
`ifdef PULSE_CNT_EDGE_EN
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 1, 0, 4'd2, 4'd0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd2, 4'd0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'd2, 4'd0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd2, 4'd1, 0, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 1, 0, 4'd2, 4'd1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'd2, 4'd1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd2, 4'd2, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4'd2, 4'd2, 0, 0, 1));
`else
    // idle: x high but no start
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 1, 0, 4'd5, 4'd0, 0, 0, 0));
    // basic count to 5
    tbl.push_back(mk(1, 0, 1, 0, 4'd5, 4'd0, 0, 1, 0));
    for (int i = 1; i < 5; i++) tbl.push_back(mk(0, 0, 1, 0, 4'd5, 4'(i), 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd5, 4'd5, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 4'd5, 4'd5, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 4'd5, 4'd5, 0, 0, 1));
    // restart from DONE, then abort+start together at q=3
    tbl.push_back(mk(1, 0, 1, 0, 4'd5, 4'd0, 0, 1, 0));
    for (int i = 1; i < 4; i++) tbl.push_back(mk(0, 0, 1, 0, 4'd5, 4'(i), 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 0, 4'd5, 4'd3, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 4'd5, 4'd0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd5, 4'd1, 0, 1, 0));
    // auto-rearm with limit 3
    tbl.push_back(mk(0, 1, 0, 1, 4'd3, 4'd1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 4'd3, 4'd0, 0, 1, 0));
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(0, 0, 1, 1, 4'd3, 4'd1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 4'd3, 4'd2, 0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 4'd3, 4'd3, 1, 0, 1));
      tbl.push_back(mk(0, 0, 1, 1, 4'd3, 4'd0, 0, 1, 0));
    end
    // limit 1: first event terminates
    tbl.push_back(mk(0, 1, 0, 0, 4'd1, 4'd0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'd1, 4'd0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd1, 4'd1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 4'd1, 4'd1, 0, 0, 1));
`endif

    do_reset();
    chk("reset_q", q, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_g", g, 0);

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].a, tbl[i].xx, tbl[i].ar, tbl[i].lim);
      chk($sformatf("vec%0d_q", i), q, tbl[i].eq);
      chk($sformatf("vec%0d_g", i), g, tbl[i].eg);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("vec%0d_done", i), done, tbl[i].ed);
    end

    // Full range: limit 0 on both widths, x alternating so both event modes count every other cycle.
    do_reset();
    limit8 = 8'd0;
    step(1, 0, 0, 0, 4'd0);
    first4 = 0; first8 = 0; q4_at = -1; q8_at = -1;
    for (int c = 1; c <= 1100 && first8 == 0; c++) begin
      step(0, 0, c[0], 0, 4'd0);
      if (g && first4 == 0) begin first4 = c; q4_at = q; end
      if (g8 && first8 == 0) begin first8 = c; q8_at = q8; end
    end
    chk("full4_cycle", first4, 31);
    chk("full4_q", q4_at, 0);
    chk("full8_cycle", first8, 511);
    chk("full8_q", q8_at, 0);
    chk("full8_done", done8, 1);

    // Reset asserted mid-run clears outputs immediately.
    do_reset();
    step(1, 0, 0, 0, 4'd7);
    step(0, 0, 1, 0, 4'd7);
    step(0, 0, 0, 0, 4'd7);
    step(0, 0, 1, 0, 4'd7);
    chk("midrun_q_before", q, 2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrun_q", q, 0);
    chk("midrun_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("midrun_g", g, 0);

    // Randomised run against the reference model.
    do_reset();
    model_reset();
    begin
      logic s, a, xx, ar, rl;
      logic [3:0] lim;
      lim = 4'd3; ar = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        s  = ($urandom_range(0, 99) < 7);
        a  = ($urandom_range(0, 99) < 3);
        xx = $urandom_range(0, 1);
        if ($urandom_range(0, 24) == 0)
          lim = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
        if ($urandom_range(0, 39) == 0) ar = ~ar;
        rl = ($urandom_range(0, 299) != 0);
        drive(s, a, xx, ar, lim);
        reset = rl;
        if (!rl) model_reset();
        else model_step(s, a, xx, ar, int'(lim));
        @(posedge clk);
        #1;
        chk($sformatf("rnd%0d_q", i), q, m_q);
        chk($sformatf("rnd%0d_g", i), g, m_g);
        chk($sformatf("rnd%0d_busy", i), busy, m_mode == 1);
        chk($sformatf("rnd%0d_done", i), done, m_mode == 2);
        chk($sformatf("rnd%0d_excl", i), busy & done, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_count_ctrl.md
# pulse_count_ctrl

Parametrised controller/datapath pair that counts qualifying events on a serial input `x` after a start command and flags when a programmable terminal count is reached. It generalises the fixed 4-bit count-to-all-ones controller to `WIDTH` bits, a runtime terminal value, an abort path and an optional auto-rearm mode. It sits between a host-side start/limit register and any downstream logic that consumes the one-cycle `g` strobe.

## Interface
- `WIDTH`, 4, counter width in bits (≥ 2)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin (or restart) a count; sampled each cycle
- `abort`  in  1  cancel current count, return to IDLE
- `x`  in  1  event input
- `limit`  in  WIDTH  terminal count; 0 means 2^WIDTH; sampled every cycle
- `auto_rearm`  in  1  1 = restart automatically after terminal count
- `q`  out  WIDTH  current count
- `g`  out  1  terminal-count strobe, one cycle
- `busy`  out  1  high in COUNT
- `done`  out  1  high in DONE

## Operation
- States: IDLE (00), COUNT (01), DONE (10); encoding 11 unreachable, recovers to IDLE.
- Event: `x` = 1 in a COUNT cycle (level mode, default).
- Priority per cycle: `abort` > `start` > event.
- IDLE: q held. `start` → q ← 0, go COUNT.
- COUNT: `abort` → IDLE, q held. `start` → q ← 0, stay COUNT, event ignored. Event with q ≠ limit−1 (mod 2^WIDTH) → q ← q+1. Event with q = limit−1 → q ← q+1 (wraps to 0 when limit = 0), g ← 1, go DONE.
- DONE: q holds terminal value. `abort` → IDLE. `start` or `auto_rearm` → q ← 0, go COUNT; event that cycle ignored. Otherwise stay.
- Counter arithmetic modulo 2^WIDTH; no saturation.
- limit = 1: first event terminates. limit = 0: terminates after 2^WIDTH events, q reads 0 in DONE.
- `limit` change mid-count takes effect on the next event compare; if new limit−1 < q, count continues through wrap until equality.

## Timing
- All outputs registered. Reset: state IDLE, q = 0, g = 0, busy = 0, done = 0, edge register = 0.
- `start` at edge n → busy = 1, q = 0 after edge n.
- Event at edge n → q updated after edge n (1-cycle latency).
- Terminal event at edge n → g = 1 and done = 1 after edge n; g = 0 after edge n+1 regardless of inputs.
- Auto-rearm: DONE lasts exactly one cycle; busy returns after edge n+1; minimum 1 dead cycle between runs.
- `reset` low mid-run: immediate return to reset values, no g.
- busy and done are never high together.

## Configuration
- `PULSE_CNT_EDGE_EN` defined: event = rising edge of `x` (x = 1 and previous-cycle x = 0, via an internal register sampling `x` every cycle in all states); a held-high `x` counts once.
- Undefined: level mode as above; no edge register synthesised.

## Test plan
- Reset/IDLE: hold reset low 2 cycles, release, x = 1, no start for 5 cycles → q = 0, busy = done = g = 0.
- Basic count: WIDTH = 4, limit = 5, start 1 cycle, x = 1 continuously → q = 1..5 on successive edges, g high exactly one cycle when q = 5, done stays 1, q holds 5.
- Full range: limit = 0, x = 1 → g after 16 events, q = 0 in DONE; with WIDTH = 8 g after 256 events.
- Priority: in COUNT at q = 3 assert start and abort together → IDLE, q = 3; next start alone with x = 1 → q = 0 that cycle, then 1.
- Auto-rearm: limit = 3, auto_rearm = 1, x = 1 → g pulses every 4 cycles (3 counts + 1 DONE), q sequence 1,2,3,0,1,2,3.
- Edge mode (PULSE_CNT_EDGE_EN): limit = 2, x high 4 cycles, low 1, high 1 → g once, on the second rising edge; level build gives g after 2 cycles instead.
